ahb_mtx_in_hold: RTL and testbench
==================================

AHB_MTX_IN_HOLD -- requirements
Module: ahb_mtx_in_hold

Interface
REQ-001 Clocking: one clock, HCLK; reset HRESET is synchronous and active-high; no other clock or reset exists.
REQ-002 HCLK  in  1  AHB system clock.
REQ-003 HRESET  in  1  synchronous, active-high reset.
REQ-004 HSELS, HTRANSS[1:0], HWRITES, HSIZES[2:0], HBURSTS[2:0], HPROTS[3:0], HMASTLOCKS  in  1/2/1/3/3/4/1  master address phase.
REQ-005 HADDRS  in  32  master address.
REQ-006 HREADYS  in  1  bus HREADY as seen by the master layer.
REQ-007 HREADYOUTS  out  1  ready returned to the master.
REQ-008 HRESPS  out  1  response returned to the master (0=OKAY, 1=ERROR).
REQ-009 req_out  out  1  request to the output-stage arbiters; equivalent to HSELM at the output stage.
REQ-010 HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM  out  32/2/1/3/3/4/1  address phase toward the matrix.
REQ-011 addr_accept  in  1  output stage accepted this port's address phase this cycle (granted and HREADYM=1).
REQ-012 HREADYM, HRESPM  in  1/1  data-phase ready and response from the selected output stage.
REQ-013 held_tran  out  1  matrix outputs are sourced from the hold register.

Function
REQ-014 valid_s = HSELS & HTRANSS[1] & HREADYS; NONSEQ and SEQ are valid; IDLE and BUSY are not.
REQ-015 States: IDLE, PEND, DATA; state register only; encoding defined in the package.
REQ-016 IDLE: HREADYOUTS=1, HRESPS=0; valid_s & addr_accept -> DATA (zero-wait pass-through); valid_s & !addr_accept -> PEND, capture the address phase.
REQ-017 PEND: held_tran=1; req_out=1; HREADYOUTS=0; master-side input changes are ignored; addr_accept -> DATA the next cycle.
REQ-018 DATA: HREADYOUTS=HREADYM and HRESPS=HRESPM combinationally, with zero added latency.
REQ-019 DATA with HREADYM=1: next transfer valid_s & addr_accept -> DATA; valid_s & !addr_accept -> PEND (capture); otherwise -> IDLE.
REQ-020 Output mux: held_tran ? hold register : live master inputs; HTRANSM is forced to 2'b00 when !held_tran & !HSELS.
REQ-021 req_out = held_tran | (HSELS & HTRANSS != 2'b00).
REQ-022 BUSY in DATA: passed through to the matrix, with no capture or state change.
REQ-023 Two-cycle ERROR: HRESPM=1/HREADYM=0 is passed through; if the master drives IDLE in the second cycle, go to IDLE with no capture; a NONSEQ in the second cycle follows REQ-019.
REQ-024 Capture and accept in the same cycle as an ERROR completion: the new transfer is honoured; no transfer is duplicated or dropped.
REQ-025 The hold register loads only on the IDLE->PEND or DATA->PEND transition and holds its value otherwise.

Reset
REQ-026 HRESET=1 at a clock edge: state=IDLE, held_tran=0, hold register=0, HREADYOUTS=1, HRESPS=0, HTRANSM=2'b00, and the lock flag clears.
REQ-027 Reset while in PEND or DATA discards the pending transfer; no request remains after reset deasserts.

Configuration
REQ-028 Macro AHB_MTX_IN_HOLD_LOCK_EN defined: HMASTLOCKM follows the captured/live HMASTLOCKS; a lock flag keeps req_out=1 across IDLE cycles between locked transfers until an unlocked transfer or IDLE with HMASTLOCKS=0.
REQ-029 Macro undefined: HMASTLOCKS is ignored, HMASTLOCKM=0, and no lock flag exists.

Structure
REQ-030 Package ahb_mtx_pkg holds: HTRANS/HBURST encodings, the state enum, and the address width (32) and protection width (4) constants.
REQ-031 One sub-module, ahb_mtx_addr_hold: the enable-loaded address-phase register (all address-phase fields); the FSM and muxes stay in ahb_mtx_in_hold.

Verification
REQ-032 NONSEQ to 0x2000_0000 with addr_accept=1 in the same cycle -> held_tran=0, HADDRM=0x2000_0000 in that cycle, HREADYOUTS=HREADYM in the next cycle.
REQ-033 NONSEQ to 0x4000_0010 with addr_accept low for 3 cycles -> held_tran=1 and HREADYOUTS=0 for 3 cycles, HADDRM constant at 0x4000_0010, DATA entered the cycle after accept.
REQ-034 INCR4 with HREADYM=0 for 2 cycles on beat 2 -> master sees 2 wait states; 4 beats delivered in order, none duplicated.
REQ-035 ERROR on a data phase, then master drives IDLE in the second cycle -> HRESPS=1 for 2 cycles, HREADYOUTS 0 then 1, state IDLE, req_out=0.
REQ-036 HRESET=1 while in PEND -> next cycle held_tran=0, HTRANSM=2'b00, HREADYOUTS=1.
REQ-037 With AHB_MTX_IN_HOLD_LOCK_EN: locked read, IDLE, locked write -> req_out=1 throughout and HMASTLOCKM=1; without the macro -> HMASTLOCKM=0.

Source files
------------

// File: rtl/ahb_mtx_pkg.sv
// Shared encodings and types for the AHB matrix input stage.
// The optional lock feature is enabled with the AHB_MTX_IN_HOLD_LOCK_EN macro.
package ahb_mtx_pkg;

    localparam int ADDR_W = 32;
    localparam int PROT_W = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        trans;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [PROT_W-1:0] prot;
        logic              mastlock;
    } addr_phase_t;

endpackage

// File: rtl/ahb_mtx_addr_hold.sv
// Enable-loaded copy of a master address phase, used while the matrix is not yet ready for it.
module ahb_mtx_addr_hold
    import ahb_mtx_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        load,
    input  addr_phase_t live_phase,
    output addr_phase_t held_phase
);

    addr_phase_t hold_reg;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hold_reg <= '0;
        end else if (load) begin
            hold_reg <= live_phase;
        end
    end

    assign held_phase = hold_reg;

endmodule

// File: rtl/ahb_mtx_in_hold.sv
// AHB matrix input stage: passes address phases through or holds them until the output stage accepts.
// Define AHB_MTX_IN_HOLD_LOCK_EN to forward HMASTLOCK and keep the request up across locked sequences.
module ahb_mtx_in_hold
    import ahb_mtx_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSELS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [PROT_W-1:0] HPROTS,
    input  logic              HMASTLOCKS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic              req_out,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [PROT_W-1:0] HPROTM,
    output logic              HMASTLOCKM,
    input  logic              addr_accept,
    input  logic              HREADYM,
    input  logic              HRESPM,
    output logic              held_tran
);

    state_t      state_reg, state_next;
    logic        valid_s, busy_s, load, live_lock, lock_term;
    addr_phase_t live_phase, held_phase, out_phase;

    assign valid_s = HSELS & HTRANSS[1] & HREADYS;
    assign busy_s  = HSELS & HREADYS & (htrans_t'(HTRANSS) == HTRANS_BUSY);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A BUSY between beats keeps the data phase open rather than dropping to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (valid_s) state_next = addr_accept ? ST_DATA : ST_PEND;
            ST_PEND: if (addr_accept) state_next = ST_DATA;
            ST_DATA: begin
                if (HREADYM) begin
                    if (valid_s)      state_next = addr_accept ? ST_DATA : ST_PEND;
                    else if (!busy_s) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign load      = (state_next == ST_PEND) && (state_reg != ST_PEND);
    assign held_tran = (state_reg == ST_PEND);

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        case (state_reg)
            ST_PEND: HREADYOUTS = 1'b0;
            ST_DATA: begin
                HREADYOUTS = HREADYM;
                HRESPS     = HRESPM;
            end
            default: ;
        endcase
    end

    assign live_phase = '{
        addr:     HADDRS,
        trans:    HSELS ? HTRANSS : 2'b00,
        write:    HWRITES,
        size:     HSIZES,
        burst:    HBURSTS,
        prot:     HPROTS,
        mastlock: live_lock
    };

    ahb_mtx_addr_hold u_addr_hold (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .load       (load),
        .live_phase (live_phase),
        .held_phase (held_phase)
    );

    assign out_phase  = held_tran ? held_phase : live_phase;
    assign HADDRM     = out_phase.addr;
    assign HTRANSM    = HRESET ? 2'b00 : out_phase.trans;
    assign HWRITEM    = out_phase.write;
    assign HSIZEM     = out_phase.size;
    assign HBURSTM    = out_phase.burst;
    assign HPROTM     = out_phase.prot;
    assign HMASTLOCKM = out_phase.mastlock;

`ifdef AHB_MTX_IN_HOLD_LOCK_EN
    logic lock_reg, lock_next;

    assign live_lock = HMASTLOCKS;

    // The lock follows each master cycle the layer completes; a held phase does not update it.
    always_comb begin
        lock_next = lock_reg;
        if ((state_reg != ST_PEND) && HSELS && HREADYS) begin
            lock_next = HMASTLOCKS;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lock_reg <= 1'b0;
        end else begin
            lock_reg <= lock_next;
        end
    end

    assign lock_term = lock_reg;
`else
    logic unused_mastlock;

    assign unused_mastlock = HMASTLOCKS;
    assign live_lock       = 1'b0;
    assign lock_term       = 1'b0;
`endif

    assign req_out = held_tran | (HSELS & (HTRANSS != 2'b00)) | lock_term;

endmodule

// File: tb/tb_ahb_mtx_in_hold.sv
// Directed bench for ahb_mtx_in_hold; HREADYS is looped back from HREADYOUTS as on a real master layer.
module tb_ahb_mtx_in_hold;

`ifdef AHB_MTX_IN_HOLD_LOCK_EN
    localparam logic LOCK = 1'b1;
`else
    localparam logic LOCK = 1'b0;
`endif

    logic        HCLK, HRESET;
    logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
    logic [1:0]  HTRANSS;
    logic [2:0]  HSIZES, HBURSTS;
    logic [3:0]  HPROTS;
    logic [31:0] HADDRS;
    logic        HREADYOUTS, HRESPS, req_out, held_tran;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM, HMASTLOCKM;
    logic [2:0]  HSIZEM, HBURSTM;
    logic [3:0]  HPROTM;
    logic        addr_accept, HREADYM, HRESPM;

    int total = 0;
    int bad   = 0;

    ahb_mtx_in_hold dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSELS(HSELS), .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HADDRS(HADDRS),
        .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .req_out(req_out),
        .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
        .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_accept(addr_accept), .HREADYM(HREADYM), .HRESPM(HRESPM),
        .held_tran(held_tran)
    );

    assign HREADYS = HREADYOUTS;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string name);
        @(posedge HCLK);
        #1;
        $display("[%0t] step %s", $time, name);
    endtask

    task automatic drv(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] bu, input logic lk,
                       input logic acc, input logic rdy, input logic rsp);
        HSELS       = sel;
        HTRANSS     = tr;
        HADDRS      = a;
        HWRITES     = wr;
        HBURSTS     = bu;
        HMASTLOCKS  = lk;
        addr_accept = acc;
        HREADYM     = rdy;
        HRESPM      = rsp;
        #1;
    endtask

    initial begin
        HSIZES = 3'b010;
        HPROTS = 4'b0011;
        HRESET = 1'b1;
        drv(0, 2'b00, 32'h0, 0, 3'd0, 0, 0, 1, 0);

        step("reset");
        chk("rst_held", held_tran, 0);
        chk("rst_rdyout", HREADYOUTS, 1);
        chk("rst_resp", HRESPS, 0);
        chk("rst_htrans", HTRANSM, 2'b00);
        chk("rst_req", req_out, 0);
        HRESET = 1'b0;

        // zero-wait pass-through
        step("r032_nonseq");
        drv(1, 2'b10, 32'h2000_0000, 0, 3'd0, 0, 1, 1, 0);
        chk("r032_held", held_tran, 0);
        chk("r032_addr", HADDRM, 32'h2000_0000);
        chk("r032_trans", HTRANSM, 2'b10);
        chk("r032_req", req_out, 1);
        step("r032_data");
        drv(0, 2'b00, 32'h0, 0, 3'd0, 0, 0, 0, 0);
        chk("r032_rdy_lo", HREADYOUTS, 0);
        HREADYM = 1'b1; #1;
        chk("r032_rdy_hi", HREADYOUTS, 1);
        chk("r032_req_off", req_out, 0);

        // held for three cycles
        step("r033_req");
        drv(1, 2'b10, 32'h4000_0010, 1, 3'd0, 0, 0, 1, 0);
        chk("r033_held0", held_tran, 0);
        for (int i = 0; i < 3; i++) begin
            step("r033_pend");
            drv(1, 2'b00, 32'hDEAD_0000 + i, 0, 3'd0, 0, (i == 2), 1, 0);
            chk("r033_held", held_tran, 1);
            chk("r033_rdyout", HREADYOUTS, 0);
            chk("r033_addr", HADDRM, 32'h4000_0010);
            chk("r033_trans", HTRANSM, 2'b10);
            chk("r033_write", HWRITEM, 1);
            chk("r033_req", req_out, 1);
        end
        chk("r033_size", HSIZEM, 3'b010);
        chk("r033_prot", HPROTM, 4'b0011);
        step("r033_data");
        drv(0, 2'b00, 32'h0, 0, 3'd0, 0, 0, 0, 0);
        chk("r033_held_d", held_tran, 0);
        chk("r033_data_lo", HREADYOUTS, 0);
        HREADYM = 1'b1; #1;
        chk("r033_data_hi", HREADYOUTS, 1);

        // INCR4 with two wait states on beat 2 and a BUSY before beat 4
        step("r034_b1");
        drv(1, 2'b10, 32'h100, 0, 3'd3, 0, 1, 1, 0);
        chk("r034_b1_addr", HADDRM, 32'h100);
        chk("r034_burst", HBURSTM, 3'd3);
        step("r034_b2");
        drv(1, 2'b11, 32'h104, 0, 3'd3, 0, 1, 1, 0);
        chk("r034_b2_rdy", HREADYOUTS, 1);
        chk("r034_b2_addr", HADDRM, 32'h104);
        chk("r034_b2_trans", HTRANSM, 2'b11);
        step("r034_w1");
        drv(1, 2'b11, 32'h108, 0, 3'd3, 0, 0, 0, 0);
        chk("r034_w1_rdy", HREADYOUTS, 0);
        chk("r034_w1_addr", HADDRM, 32'h108);
        step("r034_w2");
        drv(1, 2'b11, 32'h108, 0, 3'd3, 0, 0, 0, 0);
        chk("r034_w2_rdy", HREADYOUTS, 0);
        step("r034_b3");
        drv(1, 2'b11, 32'h108, 0, 3'd3, 0, 1, 1, 0);
        chk("r034_b3_rdy", HREADYOUTS, 1);
        chk("r034_b3_addr", HADDRM, 32'h108);
        step("r022_busy");
        drv(1, 2'b01, 32'h10C, 0, 3'd3, 0, 0, 1, 0);
        chk("r022_trans", HTRANSM, 2'b01);
        chk("r022_addr", HADDRM, 32'h10C);
        chk("r022_held", held_tran, 0);
        step("r034_b4");
        drv(1, 2'b11, 32'h10C, 0, 3'd3, 0, 0, 0, 0);
        chk("r034_b4_data", HREADYOUTS, 0);
        HREADYM = 1'b1; addr_accept = 1'b1; #1;
        chk("r034_b4_rdy", HREADYOUTS, 1);
        chk("r034_b4_addr", HADDRM, 32'h10C);
        step("r034_end");
        drv(1, 2'b00, 32'h0, 0, 3'd0, 0, 0, 1, 0);
        chk("r034_end_rdy", HREADYOUTS, 1);
        chk("r034_end_trans", HTRANSM, 2'b00);
        chk("r034_end_req", req_out, 0);

        // two-cycle ERROR, master goes IDLE
        step("r035_a");
        drv(1, 2'b10, 32'h3000_0000, 0, 3'd0, 0, 1, 1, 0);
        step("r035_e1");
        drv(1, 2'b10, 32'h3000_0004, 0, 3'd0, 0, 0, 0, 1);
        chk("r035_e1_resp", HRESPS, 1);
        chk("r035_e1_rdy", HREADYOUTS, 0);
        step("r035_e2");
        drv(1, 2'b00, 32'h0, 0, 3'd0, 0, 0, 1, 1);
        chk("r035_e2_resp", HRESPS, 1);
        chk("r035_e2_rdy", HREADYOUTS, 1);
        step("r035_idle");
        drv(0, 2'b00, 32'h0, 0, 3'd0, 0, 0, 0, 0);
        chk("r035_idle_rdy", HREADYOUTS, 1);
        chk("r035_idle_resp", HRESPS, 0);
        chk("r035_idle_req", req_out, 0);
        chk("r035_idle_held", held_tran, 0);

        // ERROR completion with a new transfer captured in the same cycle
        step("r024_a");
        drv(1, 2'b10, 32'h5000_0000, 0, 3'd0, 0, 1, 1, 0);
        step("r024_e1");
        drv(1, 2'b10, 32'h5000_0100, 0, 3'd0, 0, 0, 0, 1);
        chk("r024_e1_resp", HRESPS, 1);
        step("r024_e2");
        drv(1, 2'b10, 32'h5000_0100, 0, 3'd0, 0, 0, 1, 1);
        chk("r024_e2_resp", HRESPS, 1);
        chk("r024_e2_rdy", HREADYOUTS, 1);
        step("r024_pend");
        drv(0, 2'b00, 32'h0, 0, 3'd0, 0, 0, 1, 0);
        chk("r024_held", held_tran, 1);
        chk("r024_addr", HADDRM, 32'h5000_0100);
        chk("r024_rdy", HREADYOUTS, 0);
        chk("r024_resp", HRESPS, 0);
        chk("r024_req", req_out, 1);

        // reset while PEND
        step("r036_rst");
        HRESET = 1'b1;
        step("r036_after");
        HRESET = 1'b0;
        drv(0, 2'b00, 32'h0, 0, 3'd0, 0, 0, 1, 0);
        chk("r036_held", held_tran, 0);
        chk("r036_trans", HTRANSM, 2'b00);
        chk("r036_rdy", HREADYOUTS, 1);
        chk("r036_req", req_out, 0);

        // locked read, IDLE, locked write
        step("r037_rd");
        drv(1, 2'b10, 32'h6000_0000, 0, 3'd0, 1, 1, 1, 0);
        chk("r037_rd_lock", HMASTLOCKM, LOCK);
        chk("r037_rd_req", req_out, 1);
        step("r037_idle");
        drv(1, 2'b00, 32'h0, 0, 3'd0, 1, 0, 1, 0);
        chk("r037_idle_req", req_out, LOCK);
        chk("r037_idle_lock", HMASTLOCKM, LOCK);
        step("r037_wr");
        drv(1, 2'b10, 32'h6000_0004, 1, 3'd0, 1, 1, 1, 0);
        chk("r037_wr_req", req_out, 1);
        chk("r037_wr_lock", HMASTLOCKM, LOCK);
        chk("r037_wr_write", HWRITEM, 1);
        step("r037_unlk");
        drv(1, 2'b00, 32'h0, 0, 3'd0, 0, 0, 1, 0);
        chk("r037_unlk_req", req_out, LOCK);
        step("r037_end");
        drv(1, 2'b00, 32'h0, 0, 3'd0, 0, 0, 1, 0);
        chk("r037_end_req", req_out, 0);
        chk("r037_end_lock", HMASTLOCKM, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
